sram_req_master: RTL
====================

// Module: sram_req_master
// PURPOSE
//  Initiator for the single-port SRAM macro interface (req/we/addr/wdata/be, rdata valid 1 cycle after req).
//  Converts a valid/ready request channel into SRAM port cycles and returns read data on a valid/ready
//  response channel. A response FIFO absorbs consumer backpressure; reads are issued only when a response
//  slot is guaranteed. Sits between cache/DMA request logic and the sram wrapper.
// PARAMETERS
//  NUM_WORDS   1024  SRAM depth in words; ADDR_WIDTH = $clog2(NUM_WORDS)
//  DATA_WIDTH  64    data width; BE_WIDTH = (DATA_WIDTH+7)/8
//  RSP_DEPTH   4     response FIFO entries, >=2; >=3 needed for 1 read/cycle throughput
// PORTS
//  clk_i         in   1           clock, all state on rising edge
//  rst_i         in   1           asynchronous reset, active-high
//  req_valid_i   in   1           request valid
//  req_ready_o   out  1           request accepted when valid&ready
//  req_we_i      in   1           1 = write, 0 = read
//  req_addr_i    in   ADDR_WIDTH  word address
//  req_wdata_i   in   DATA_WIDTH  write data
//  req_be_i      in   BE_WIDTH    byte enables (writes only)
//  rsp_valid_o   out  1           read response valid
//  rsp_ready_i   in   1           response consumed when valid&ready
//  rsp_rdata_o   out  DATA_WIDTH  read data, in request order
//  sram_req_o    out  1           SRAM chip select
//  sram_we_o     out  1           SRAM write enable
//  sram_addr_o   out  ADDR_WIDTH  SRAM address
//  sram_wdata_o  out  DATA_WIDTH  SRAM write data
//  sram_be_o     out  BE_WIDTH    SRAM byte enables
//  sram_rdata_i  in   DATA_WIDTH  SRAM read data, valid cycle after read req
//  busy_o        out  1           init sweep in progress
// BEHAVIOUR
//  - Reset (rst_i high, async): FIFO empty, inflight=0, state per CONFIGURATION; req_ready_o=0,
//    rsp_valid_o=0, sram_req_o=0, sram_we_o=0, rsp_rdata_o/sram_addr_o/wdata/be=0. An inflight read is dropped.
//  - States: INIT (sweep, optional), RUN. RUN is terminal until reset.
//  - RUN: outstanding = fifo_count + inflight (registered only; no comb path rsp_ready_i->req_ready_o).
//    req_ready_o = 1 for writes; for reads = (outstanding < RSP_DEPTH).
//  - Accepted request drives SRAM port combinationally in same cycle: sram_req_o=1, we/addr/wdata/be copied;
//    reads force sram_be_o all-ones. Otherwise sram_req_o=0, sram_we_o=0.
//  - Accepted read sets inflight=1 next cycle; that cycle sram_rdata_i is pushed into FIFO. Writes give no response.
//  - Latency: read accept at cycle N -> rsp_valid_o at N+2 (FIFO is registered, no bypass).
//  - FIFO: push and pop in same cycle keep count; pop when empty impossible; push when full impossible by credit.
//    Pointers wrap modulo RSP_DEPTH (non-power-of-2 supported).
//  - rsp_rdata_o stable while rsp_valid_o=1 and rsp_ready_i=0.
// CONFIGURATION
//  SRAM_INIT_SWEEP_EN defined: reset enters INIT; one zero write per cycle, addr 0..NUM_WORDS-1, be all-ones;
//    busy_o=1, req_ready_o=0 during INIT; after write to NUM_WORDS-1 -> RUN next cycle (NUM_WORDS+1 cycles
//    from reset release to first req_ready_o). Reset during INIT restarts at addr 0.
//  Not defined: reset enters RUN directly; busy_o tied 0; no sweep counter.
// TESTING
//  1 Write 0xDEADBEEF_CAFEF00D @5 be=0xFF, read @5 -> rsp_rdata_o=0xDEADBEEF_CAFEF00D exactly 2 cycles after read accept.
//  2 Partial write be=0x0F of 0x11223344_55667788 over prior all-ones @7, read -> 0xFFFFFFFF_55667788.
//  3 RSP_DEPTH=4, rsp_ready_i=0, 10 back-to-back reads -> exactly 4 accepted, req_ready_o=0 for reads, writes still accepted;
//    release rsp_ready_i -> all 10 responses in order, no loss/duplication.
//  4 RSP_DEPTH=3, rsp_ready_i=1, 16 consecutive reads -> one accept per cycle, 16 responses on 16 consecutive cycles.
//  5 Assert rst_i with 2 reads outstanding -> rsp_valid_o=0 immediately (async), FIFO empty, no late response after release.
//  6 SRAM_INIT_SWEEP_EN, NUM_WORDS=16 -> busy_o=1 for 16 cycles, addr 0..15 written 0, read @9 afterwards returns 0.

Source files
------------

// File: rtl/sram_req_master_if.sv
// Interface bundling the request channel, the response channel, the SRAM
// macro port and the init-sweep busy flag of sram_req_master.
// The master modport is the view of sram_req_master itself; the slave
// modport is the view of the surrounding logic (requester, consumer, SRAM).
interface sram_req_master_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 64,
   parameter int BE_WIDTH   = (DATA_WIDTH + 7) / 8
);
   // request channel
   logic                  req_valid_i;
   logic                  req_ready_o;
   logic                  req_we_i;
   logic [ADDR_WIDTH-1:0] req_addr_i;
   logic [DATA_WIDTH-1:0] req_wdata_i;
   logic [BE_WIDTH-1:0]   req_be_i;
   // response channel
   logic                  rsp_valid_o;
   logic                  rsp_ready_i;
   logic [DATA_WIDTH-1:0] rsp_rdata_o;
   // SRAM macro port
   logic                  sram_req_o;
   logic                  sram_we_o;
   logic [ADDR_WIDTH-1:0] sram_addr_o;
   logic [DATA_WIDTH-1:0] sram_wdata_o;
   logic [BE_WIDTH-1:0]   sram_be_o;
   logic [DATA_WIDTH-1:0] sram_rdata_i;
   // status
   logic                  busy_o;

   modport master (
      input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i,
      input  rsp_ready_i, sram_rdata_i,
      output req_ready_o, rsp_valid_o, rsp_rdata_o,
      output sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o,
      output busy_o
   );

   modport slave (
      output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i,
      output rsp_ready_i, sram_rdata_i,
      input  req_ready_o, rsp_valid_o, rsp_rdata_o,
      input  sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o,
      input  busy_o
   );
endinterface

// File: rtl/sram_req_master.sv
// sram_req_master: turns a valid/ready request stream into single-port SRAM
// cycles and returns read data in order through a small response FIFO.
//
// Handshake semantics (both channels): a beat transfers on a rising clock
// edge where valid and ready are both high. Read requests are only accepted
// when a FIFO slot is guaranteed (credit = FIFO count + read in flight), so
// the FIFO can never overflow and a request never has to be cancelled.
// req_ready_o depends only on registered state and req_we_i, never on
// rsp_ready_i.
//
// Optional feature macro: SRAM_INIT_SWEEP_EN. When defined, reset enters an
// INIT state that writes zero to every SRAM word (one per cycle, addr 0 up)
// before requests are accepted; busy_o is high while sweeping. When not
// defined, reset enters RUN directly and busy_o is tied low.
//
// dbg_state exposes the FSM state (0 = INIT, 1 = RUN).
module sram_req_master #(
   parameter int NUM_WORDS  = 1024,
   parameter int DATA_WIDTH = 64,
   parameter int RSP_DEPTH  = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   sram_req_master_if.master bus,
   output logic              dbg_state
);

   localparam int ADDR_WIDTH = $clog2(NUM_WORDS);
   localparam int BE_WIDTH   = (DATA_WIDTH + 7) / 8;
   localparam int PTR_W      = $clog2(RSP_DEPTH);
   localparam int CNT_W      = $clog2(RSP_DEPTH + 1);
   localparam int OUT_W      = $clog2(RSP_DEPTH + 2);

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

`ifdef SRAM_INIT_SWEEP_EN
   localparam state_t RESET_STATE = ST_INIT;
`else
   localparam state_t RESET_STATE = ST_RUN;
`endif

   state_t                state;
   state_t                state_nxt;
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;
   logic                  inflight;
   logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
   logic [OUT_W-1:0]      outstanding;
   logic                  run;
   logic                  sweeping;
   logic                  req_ready;
   logic                  accept;
   logic                  read_accept;
   logic                  rsp_valid;
   logic                  push;
   logic                  pop;
`ifdef SRAM_INIT_SWEEP_EN
   logic [ADDR_WIDTH-1:0] sweep_addr;
`endif

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Outputs are forced idle while reset is held, even though the state
   // register already holds its reset value.
   assign run         = (state == ST_RUN) && !rst_i;
`ifdef SRAM_INIT_SWEEP_EN
   assign sweeping    = (state == ST_INIT) && !rst_i;
   assign bus.busy_o  = (state == ST_INIT);
`else
   assign sweeping    = 1'b0;
   assign bus.busy_o  = 1'b0;
`endif

   assign outstanding = OUT_W'(count) + OUT_W'(inflight);
   assign req_ready   = run && (bus.req_we_i || (outstanding < OUT_W'(RSP_DEPTH)));
   assign accept      = bus.req_valid_i && req_ready;
   assign read_accept = accept && !bus.req_we_i;

   assign rsp_valid   = (count != '0);
   assign push        = inflight;
   assign pop         = rsp_valid && bus.rsp_ready_i;

   assign bus.req_ready_o = req_ready;
   assign bus.rsp_valid_o = rsp_valid;
   assign bus.rsp_rdata_o = rsp_valid ? fifo_mem[rd_ptr] : '0;
   assign dbg_state       = logic'(state);

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= RESET_STATE;
      else       state <= state_nxt;
   end

   // Next state: INIT leaves after the last word has been written; RUN is terminal.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_INIT: begin
`ifdef SRAM_INIT_SWEEP_EN
            if (sweep_addr == ADDR_WIDTH'(NUM_WORDS - 1)) state_nxt = ST_RUN;
`else
            state_nxt = ST_RUN;
`endif
         end
         default: state_nxt = ST_RUN;
      endcase
   end

   // SRAM port: sweep write during INIT, else the accepted request in the same cycle.
   always_comb begin
      bus.sram_req_o   = 1'b0;
      bus.sram_we_o    = 1'b0;
      bus.sram_addr_o  = '0;
      bus.sram_wdata_o = '0;
      bus.sram_be_o    = '0;
      if (sweeping) begin
         bus.sram_req_o  = 1'b1;
         bus.sram_we_o   = 1'b1;
`ifdef SRAM_INIT_SWEEP_EN
         bus.sram_addr_o = sweep_addr;
`endif
         bus.sram_be_o   = '1;
      end else if (accept) begin
         bus.sram_req_o   = 1'b1;
         bus.sram_we_o    = bus.req_we_i;
         bus.sram_addr_o  = bus.req_addr_i;
         bus.sram_wdata_o = bus.req_wdata_i;
         bus.sram_be_o    = bus.req_we_i ? bus.req_be_i : {BE_WIDTH{1'b1}};
      end
   end

`ifdef SRAM_INIT_SWEEP_EN
   // Sweep address walks 0..NUM_WORDS-1 while in INIT; reset restarts it.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                 sweep_addr <= '0;
      else if (state == ST_INIT) sweep_addr <= sweep_addr + ADDR_WIDTH'(1);
   end
`endif

   // A read accepted this cycle has its data on sram_rdata_i next cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) inflight <= 1'b0;
      else       inflight <= read_accept;
   end

   // Response FIFO pointers and occupancy; pointers wrap at RSP_DEPTH.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // FIFO storage; contents are only observed through rsp_rdata_o when valid.
   always_ff @(posedge clk_i) begin
      if (push) fifo_mem[wr_ptr] <= bus.sram_rdata_i;
   end

endmodule
